// File: rtl/poseidon_stream_pkg.sv
// Shared types for the Poseidon input stream.
//   WIDTH/BEATS : field-element width and beats per packet (state width t)
//   field_t     : one beat payload
//   state_t     : array of BEATS field elements, beat 0 at index 0
//   asm_state_e : input assembler control states
//   pack_state  : flattens a state_t into a vector, beat k at [k*WIDTH +: WIDTH]
package poseidon_stream_pkg;

    localparam int unsigned WIDTH   = 255;
    localparam int unsigned BEATS   = 3;
    localparam int unsigned STATE_W = WIDTH * BEATS;
    localparam int unsigned IDX_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef logic [WIDTH-1:0] field_t;
    typedef field_t state_t [BEATS];

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FULL    = 2'd1,
        DROP    = 2'd2
    } asm_state_e;

    function automatic logic [STATE_W-1:0] pack_state(input state_t s);
        logic [STATE_W-1:0] v;
        v = '0;
        for (int k = 0; k < int'(BEATS); k++) begin
            v[k*WIDTH +: WIDTH] = s[k];
        end
        return v;
    endfunction

endpackage

// File: rtl/poseidon_input_assembler.sv
// Poseidon input assembler: collects BEATS beats of WIDTH bits into one
// state vector for the permutation core. Double-buffered (assembly register
// plus output register); framing errors are flagged and the stream is
// resynchronised on in_last.
//   clk, resetn         : clock, synchronous active-low reset
//   in_valid/in_ready   : beat handshake, in_last marks the final beat
//   in_payload          : beat data
//   out_valid/out_ready : assembled state handshake, out_state = beats 0..BEATS-1 (beat 0 in LSBs)
//   err_early_last      : one-cycle pulse, last seen before the final beat
//   err_missing_last    : one-cycle pulse, final beat arrived without last
//   pkt_count           : packets delivered on the out handshake (wraps)
module poseidon_input_assembler
    import poseidon_stream_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [WIDTH-1:0]         in_payload,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BEATS*WIDTH-1:0]   out_state,
    output logic                     err_early_last,
    output logic                     err_missing_last,
    output logic [CNT_W-1:0]         pkt_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    asm_state_e          r_state;
    logic [IDX_W-1:0]    r_idx;
    state_t              r_asm;
    logic                r_out_valid;
    logic [STATE_W-1:0]  r_out_state;
    logic                r_err_early;
    logic                r_err_missing;
    logic [CNT_W-1:0]    r_pkt_count;

    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_slot_free;
    state_t              w_load;
    logic [STATE_W-1:0]  w_load_vec;
    logic [STATE_W-1:0]  w_full_vec;

    // Ready depends only on registered state, never on in_valid.
    assign in_ready    = resetn && (r_state != FULL);
    assign w_in_fire   = in_valid && in_ready;
    assign w_out_fire  = r_out_valid && out_ready;
    assign w_slot_free = !r_out_valid || out_ready;

    // Direct load path: stored beats plus the final beat straight from the input.
    always_comb begin
        w_load            = r_asm;
        w_load[BEATS-1]   = in_payload;
    end

    assign w_load_vec = pack_state(w_load);
    assign w_full_vec = pack_state(r_asm);

    // Control FSM, assembly register and output register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= COLLECT;
            r_idx         <= '0;
            for (int k = 0; k < int'(BEATS); k++) begin
                r_asm[k] <= '0;
            end
            r_out_valid   <= 1'b0;
            r_out_state   <= '0;
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;
            r_pkt_count   <= '0;
        end else begin
            r_err_early   <= 1'b0;
            r_err_missing <= 1'b0;

            // Handshake retires the output; a load below overrides this.
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
                r_pkt_count <= r_pkt_count + CNT_W'(1);
            end

            case (r_state)
                COLLECT: begin
                    if (w_in_fire) begin
                        if (r_idx != LAST_IDX) begin
                            if (in_last) begin
                                r_idx       <= '0;
                                r_err_early <= 1'b1;
                            end else begin
                                r_asm[r_idx] <= in_payload;
                                r_idx        <= r_idx + IDX_W'(1);
                            end
                        end else if (in_last) begin
                            r_idx <= '0;
                            if (w_slot_free) begin
                                r_out_state <= w_load_vec;
                                r_out_valid <= 1'b1;
                            end else begin
                                // Output still held: park the packet and stall input.
                                r_asm[BEATS-1] <= in_payload;
                                r_state        <= FULL;
                            end
                        end else begin
                            r_idx         <= '0;
                            r_err_missing <= 1'b1;
                            r_state       <= DROP;
                        end
                    end
                end

                FULL: begin
                    if (w_out_fire) begin
                        r_out_state <= w_full_vec;
                        r_out_valid <= 1'b1;
                        r_state     <= COLLECT;
                    end
                end

                DROP: begin
                    // Discard everything up to and including the next last.
                    if (w_in_fire && in_last) begin
                        r_idx   <= '0;
                        r_state <= COLLECT;
                    end
                end

                default: begin
                    r_idx   <= '0;
                    r_state <= COLLECT;
                end
            endcase
        end
    end

    assign out_valid        = r_out_valid;
    assign out_state        = r_out_state;
    assign err_early_last   = r_err_early;
    assign err_missing_last = r_err_missing;
    assign pkt_count        = r_pkt_count;

endmodule
